// File: rtl/sr_latch_writer_pkg.sv
// Shared definitions for the SR latch bank write controller: default timing,
// FSM state encoding and a small helper for sizing the stage counter.
package sr_latch_writer_pkg;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;
    localparam int DEF_SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Longest of the timed stages; the stage counter must be able to hold it.
    function automatic int max_stage_len(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sr_latch_writer_sync.sv
// Per-bit multi-flop synchronizer bringing the asynchronous latch Q outputs
// into the clk domain. All stages clear to 0 on reset.
module sync_nff
    import sr_latch_writer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/sr_latch_writer.sv
// Write-side controller for a bank of gated SR latches: sequences R/S setup,
// the shared enable pulse and hold, then checks the synchronized Q readback.
module sr_latch_writer
    import sr_latch_writer_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic [WIDTH-1:0] latch_r,
    output logic [WIDTH-1:0] latch_s,
    output logic             latch_e,
    input  logic [WIDTH-1:0] latch_q,
    output logic             done_valid,
    output logic             done_err,
    output logic [WIDTH-1:0] err_bits
);

    localparam int MAX_LEN = max_stage_len(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, SYNC_STAGES);
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    // Counter holds "cycles remaining minus one" so the stage ends when it reaches 0.
    function automatic logic [CNT_W-1:0] stage_load(input int len);
        return CNT_W'(len - 1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] latch_r_q, latch_r_d;
    logic [WIDTH-1:0] latch_s_q, latch_s_d;
    logic             latch_e_q, latch_e_d;
    logic             done_valid_q, done_valid_d;
    logic             done_err_q, done_err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    logic [WIDTH-1:0] q_sync;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] rst_bits;
    logic             drive_rs;

    sync_nff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (latch_q),
        .q_out (q_sync)
    );

    // Per-latch drive encoding; a bit is never both set and reset because
    // each uses the opposite polarity of the same data bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_drive
        assign set_bits[gi] =  data_d[gi] & mask_d[gi];
        assign rst_bits[gi] = ~data_d[gi] & mask_d[gi];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    data_d = wr_data;
                    mask_d = wr_mask;
                    if (wr_mask == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = stage_load(SETUP_CYCLES);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = stage_load(PULSE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = stage_load(HOLD_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = stage_load(SYNC_STAGES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Drives are decoded from the next state so every latch-facing signal
    // comes straight out of a flop and only changes on a state transition.
    always_comb begin
        drive_rs     = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        latch_s_d    = drive_rs ? set_bits : '0;
        latch_r_d    = drive_rs ? rst_bits : '0;
        latch_e_d    = (state_d == ST_PULSE);
        done_valid_d = (state_d == ST_DONE);
        err_bits_d   = err_bits_q;
        done_err_d   = done_err_q;
        if (state_d == ST_DONE) begin
            err_bits_d = (q_sync ^ data_d) & mask_d;
            done_err_d = |((q_sync ^ data_d) & mask_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            latch_r_q    <= '0;
            latch_s_q    <= '0;
            latch_e_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            err_bits_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            latch_r_q    <= latch_r_d;
            latch_s_q    <= latch_s_d;
            latch_e_q    <= latch_e_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            err_bits_q   <= err_bits_d;
        end
    end

    assign wr_ready   = (state_q == ST_IDLE);
    assign latch_r    = latch_r_q;
    assign latch_s    = latch_s_q;
    assign latch_e    = latch_e_q;
    assign done_valid = done_valid_q;
    assign done_err   = done_err_q;
    assign err_bits   = err_bits_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed bench for sr_latch_writer driving a behavioural gated SR latch
// bank, with per-cycle protocol checks on the latch drive signals.
module tb_sr_latch_writer;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic [3:0] wr_mask;
    logic [3:0] latch_r;
    logic [3:0] latch_s;
    logic       latch_e;
    logic [3:0] latch_q;
    logic       done_valid;
    logic       done_err;
    logic [3:0] err_bits;

    logic [3:0] model_q    = 4'b0000;
    logic [3:0] stuck_mask = 4'b0000;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Results of the most recent write, indexed by cycle offset j from accept edge k.
    int          res_done_at;
    int          res_done_cnt;
    logic [15:0] res_e;
    logic [15:0] res_ready;
    logic        res_err;
    logic [3:0]  res_bits;
    logic [3:0]  res_s1;
    logic [3:0]  res_r1;

    logic [3:0]  prev_r = 4'b0000;
    logic [3:0]  prev_s = 4'b0000;
    int          quiet_done;

    sr_latch_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .latch_r    (latch_r),
        .latch_s    (latch_s),
        .latch_e    (latch_e),
        .latch_q    (latch_q),
        .done_valid (done_valid),
        .done_err   (done_err),
        .err_bits   (err_bits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gated SR latch per bit: transparent while E=1, S sets, R resets.
    always @(latch_e or latch_r or latch_s) begin
        if (latch_e) model_q = (model_q | latch_s) & ~latch_r;
    end
    assign latch_q = model_q & ~stuck_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("r_and_s_exclusive", {28'd0, latch_r & latch_s}, 32'd0);
            if (latch_e) begin
                check("r_stable_while_e", {28'd0, latch_r}, {28'd0, prev_r});
                check("s_stable_while_e", {28'd0, latch_s}, {28'd0, prev_s});
            end
        end
        prev_r <= latch_r;
        prev_s <= latch_s;
    end

    // Called just after a negedge with the DUT idle; observes 12 cycles after accept.
    task automatic run_write(input logic [3:0] d, input logic [3:0] m, input bit poke);
        check("ready_at_accept", {31'd0, wr_ready}, 32'd1);
        wr_valid     = 1'b1;
        wr_data      = d;
        wr_mask      = m;
        res_done_at  = -1;
        res_done_cnt = 0;
        res_e        = '0;
        res_ready    = '0;
        res_err      = 1'b0;
        res_bits     = '0;
        res_s1       = '0;
        res_r1       = '0;
        @(posedge clk);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            res_e[j]     = latch_e;
            res_ready[j] = wr_ready;
            if (j == 1) begin
                res_s1 = latch_s;
                res_r1 = latch_r;
            end
            if (done_valid) begin
                res_done_cnt++;
                if (res_done_at < 0) begin
                    res_done_at = j;
                    res_err     = done_err;
                    res_bits    = err_bits;
                end
            end
            wr_valid = poke && (j >= 2) && (j <= 4);
            if (poke) begin
                wr_data = 4'b1111;
                wr_mask = 4'b1111;
            end
        end
        $display("write data=%b mask=%b done_at=k+%0d done_err=%b err_bits=%b q=%b",
                 d, m, res_done_at, res_err, res_bits, latch_q);
    endtask

    initial begin
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 4'b0000;
        wr_mask  = 4'b0000;
        #2 rst_n = 1'b0;

        @(negedge clk);
        check("rst_wr_ready",   {31'd0, wr_ready},   32'd1);
        check("rst_latch_e",    {31'd0, latch_e},    32'd0);
        check("rst_latch_r",    {28'd0, latch_r},    32'd0);
        check("rst_latch_s",    {28'd0, latch_s},    32'd0);
        check("rst_done_valid", {31'd0, done_valid}, 32'd0);
        check("rst_done_err",   {31'd0, done_err},   32'd0);
        check("rst_err_bits",   {28'd0, err_bits},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write: E must be high exactly at k+2 and k+3.
        run_write(4'b1010, 4'b1111, 1'b0);
        check("w1_setup_s",    {28'd0, res_s1},    32'h0000000a);
        check("w1_setup_r",    {28'd0, res_r1},    32'h00000005);
        check("w1_e_window",   {16'd0, res_e},     32'h0000000c);
        check("w1_done_at",    res_done_at,        32'd7);
        check("w1_done_cnt",   res_done_cnt,       32'd1);
        check("w1_done_err",   {31'd0, res_err},   32'd0);
        check("w1_err_bits",   {28'd0, res_bits},  32'd0);
        check("w1_busy_k1",    {31'd0, res_ready[1]}, 32'd0);
        check("w1_ready_k8",   {31'd0, res_ready[8]}, 32'd1);
        check("w1_q",          {28'd0, latch_q},   32'h0000000a);

        // Partial write with a request poked while busy, which must be dropped.
        run_write(4'b0101, 4'b0011, 1'b1);
        check("w2_setup_s",    {28'd0, res_s1},    32'h00000001);
        check("w2_setup_r",    {28'd0, res_r1},    32'h00000002);
        check("w2_done_at",    res_done_at,        32'd7);
        check("w2_done_cnt",   res_done_cnt,       32'd1);
        check("w2_err_bits",   {28'd0, res_bits},  32'd0);
        check("w2_q",          {28'd0, latch_q},   32'h00000009);

        // Empty mask: straight to DONE, no enable pulse.
        run_write(4'b1111, 4'b0000, 1'b0);
        check("w3_done_at",    res_done_at,        32'd1);
        check("w3_e_never",    {16'd0, res_e},     32'd0);
        check("w3_done_err",   {31'd0, res_err},   32'd0);
        check("w3_busy_k1",    {31'd0, res_ready[1]}, 32'd0);
        check("w3_ready_k2",   {31'd0, res_ready[2]}, 32'd1);
        check("w3_q",          {28'd0, latch_q},   32'h00000009);

        // Bit 0 stuck at 0: readback mismatch must be flagged on that bit only.
        stuck_mask = 4'b0001;
        run_write(4'b0001, 4'b1111, 1'b0);
        check("w4_done_at",    res_done_at,        32'd7);
        check("w4_done_err",   {31'd0, res_err},   32'd1);
        check("w4_err_bits",   {28'd0, res_bits},  32'h00000001);
        check("w4_hold_err",   {31'd0, done_err},  32'd1);
        check("w4_hold_bits",  {28'd0, err_bits},  32'h00000001);
        stuck_mask = 4'b0000;

        // Reset asserted during PULSE: E drops at once, no completion afterwards.
        wr_valid = 1'b1;
        wr_data  = 4'b1111;
        wr_mask  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        check("w5_in_pulse",   {31'd0, latch_e},   32'd1);
        rst_n = 1'b0;
        #1;
        check("w5_e_async_drop", {31'd0, latch_e}, 32'd0);
        quiet_done = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done_valid) quiet_done++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("w5_ready_after", {31'd0, wr_ready}, 32'd1);
        for (int j = 0; j < 10; j++) begin
            if (done_valid) quiet_done++;
            @(negedge clk);
        end
        check("w5_no_done",    quiet_done,         32'd0);
        check("w5_err_cleared", {28'd0, err_bits}, 32'd0);
        $display("reset during pulse: done pulses seen=%0d", quiet_done);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
